// File: rtl/rand_layer_ctrl.sv
// Batch sequencer for rand_layer: pulses rl_run per vector, captures each result and
// hands it downstream over valid/ready with its batch index. Watchdog on rl_valid, sync abort.
module rand_layer_ctrl #(
    parameter int HID_DIM = 4,
    parameter int N_LEN   = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CNT_W-1:0]         n_vec,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     rl_run,
    input  logic                     rl_valid,
    input  logic [HID_DIM*N_LEN-1:0] rl_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [HID_DIM*N_LEN-1:0] out_data,
    output logic [CNT_W-1:0]         out_idx
);

    localparam int VEC_W = HID_DIM * N_LEN;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               rl_run_q;
    logic               out_valid_q;
    logic [VEC_W-1:0]   out_data_q;
    logic [CNT_W-1:0]   out_idx_q;
    logic [CNT_W-1:0]   n_lat_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TMR_W-1:0]   timer_q;

    logic [TMR_W-1:0]   timer_d;
    logic [CNT_W:0]     cnt_d;
    logic               last_vec_d;
    logic               timeout_d;

    // One extra bit on the count so cnt+1 == n_vec never wraps at the maximum batch.
    always_comb begin
        timer_d    = timer_q + TMR_W'(1);
        cnt_d      = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        last_vec_d = (cnt_d == {1'b0, n_lat_q});
        timeout_d  = (timer_q == TMR_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rl_run_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            n_lat_q     <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
        end else if (abort) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rl_run_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (n_vec != '0) begin
                            n_lat_q  <= n_vec;
                            cnt_q    <= '0;
                            timer_q  <= '0;
                            rl_run_q <= 1'b1;
                            state_q  <= S_RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    timer_q <= timer_d;
                    if (rl_valid) begin
                        out_data_q  <= rl_q;
                        out_idx_q   <= cnt_q;
                        out_valid_q <= 1'b1;
                        rl_run_q    <= 1'b0;
                        state_q     <= S_HOLD;
                    end else if (timeout_d) begin
                        err_q    <= 1'b1;
                        rl_run_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                // rl_run stays low here, giving rand_layer its idle cycle between vectors.
                S_HOLD: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= cnt_d[CNT_W-1:0];
                        timer_q     <= '0;
                        if (last_vec_d) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            rl_run_q <= 1'b1;
                            state_q  <= S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    rl_run_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rl_run    = rl_run_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;

endmodule
